// File: rtl/approx_alu_seq.sv
// Sequential ALU with a lower-part-OR approximate adder (LOA) and an
// iterative shift-add multiplier that reuses the same adder each cycle.
module approx_alu_seq #(
    parameter int WIDTH = 16,
    parameter int K     = 4,
    parameter int MW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    input  logic             approx_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   y
);

    // state | meaning
    // IDLE  | waiting for an operation, in_ready=1
    // MUL   | one shift-add iteration per cycle, inputs ignored
    // HOLD  | y valid, held until out_ready; may accept the next op on drain

    localparam int SW = $clog2(WIDTH);
    localparam int CW = (MW > 1) ? $clog2(MW) : 1;
    localparam int AW = 2 * MW;

    localparam logic [WIDTH:0] ONE   = 1;
    localparam logic [WIDTH:0] KMASK = (ONE << K) - ONE;
    localparam logic [WIDTH:0] KTOP  = KMASK ^ (KMASK >> 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_MUL = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [MW-1:0]  ma_q;
    logic [MW-1:0]  mb_q;
    logic           apx_q;
    logic [AW-1:0]  acc_q;
    logic [CW-1:0]  cnt_q;
    logic [WIDTH:0] y_q;

    logic           accept;
    logic           last_iter;
    logic [WIDTH:0] alu_res;
    logic [AW-1:0]  addend;
    logic [AW-1:0]  acc_sum;
    logic [AW-1:0]  acc_step;

    // Operands are zero-extended by one bit so the top bit of the sum is the carry-out.
    function automatic logic [WIDTH:0] loa(input logic [WIDTH:0] x,
                                           input logic [WIDTH:0] z,
                                           input logic           apx);
        logic [WIDTH:0] m;
        logic [WIDTH:0] t;
        logic [WIDTH:0] s;
        m = apx ? KMASK : '0;
        t = apx ? KTOP  : '0;
        s = (x & ~m) + (z & ~m) + ((|(x & z & t)) ? (t << 1) : '0);
        return s | ((x | z) & m);
    endfunction

    always_comb begin
        alu_res = '0;
        case (sel)
            OP_ADD:  alu_res = loa({1'b0, a}, {1'b0, b}, approx_en);
            OP_AND:  alu_res = {1'b0, a & b};
            OP_OR:   alu_res = {1'b0, a | b};
            OP_XOR:  alu_res = {1'b0, a ^ b};
            OP_NOT:  alu_res = {1'b0, ~a};
            OP_SHL:  alu_res = {1'b0, (a << b[SW-1:0])};
            OP_SHR:  alu_res = {1'b0, (a >> b[SW-1:0])};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        addend    = AW'(ma_q) << cnt_q;
        acc_sum   = AW'(loa((WIDTH+1)'(acc_q), (WIDTH+1)'(addend), apx_q));
        acc_step  = mb_q[cnt_q] ? acc_sum : acc_q;
        last_iter = (cnt_q == CW'(MW - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = (sel == OP_MUL) ? MUL : HOLD;
                end
            end
            MUL: begin
                if (last_iter) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        state_nxt = (sel == OP_MUL) ? MUL : HOLD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;

    // On a mul accepted during a drain, y_q keeps the old value; out_valid is low in MUL.
    always_ff @(posedge clk) begin
        if (rst) begin
            ma_q  <= '0;
            mb_q  <= '0;
            apx_q <= 1'b0;
            acc_q <= '0;
            cnt_q <= '0;
            y_q   <= '0;
        end else if (accept) begin
            ma_q  <= a[MW-1:0];
            mb_q  <= b[MW-1:0];
            apx_q <= approx_en;
            acc_q <= '0;
            cnt_q <= '0;
            if (sel != OP_MUL) begin
                y_q <= alu_res;
            end
        end else if (state == MUL) begin
            acc_q <= acc_step;
            if (last_iter) begin
                cnt_q <= '0;
                y_q   <= (WIDTH+1)'(acc_step);
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign y = y_q;

endmodule

// File: tb/tb_approx_alu_seq.sv
// Scoreboard bench for approx_alu_seq: directed spec cases, backpressure,
// reset mid-multiply, and randomized ops against an arithmetic reference model.
module tb_approx_alu_seq;
    localparam int WIDTH = 16;
    localparam int K     = 4;
    localparam int MW    = 8;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic [2:0]       sel       = '0;
    logic             approx_en = 1'b0;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   y;

    int   ready_mode = 1;
    logic rnd_ready  = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    logic [WIDTH:0] sb[$];

    approx_alu_seq #(.WIDTH(WIDTH), .K(K), .MW(MW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sel(sel), .approx_en(approx_en),
        .out_valid(out_valid), .out_ready(out_ready), .y(y)
    );

    always #5 clk = ~clk;

    assign out_ready = (ready_mode == 2) ? rnd_ready : (ready_mode == 1);

    always @(posedge clk) rnd_ready <= ($urandom_range(0, 3) != 0);

    function automatic longint loa_ref(input longint x, input longint z, input int k);
        longint lo, c;
        if (k == 0) return x + z;
        lo = (x | z) % (longint'(1) << k);
        c  = ((x >> (k - 1)) & (z >> (k - 1))) & 1;
        return (((x >> k) + (z >> k) + c) << k) + lo;
    endfunction

    function automatic logic [WIDTH:0] model(input logic [2:0] s, input logic [WIDTH-1:0] aa,
                                             input logic [WIDTH-1:0] bb, input logic apx);
        longint x    = aa;
        longint z    = bb;
        longint mask = (longint'(1) << WIDTH) - 1;
        longint acc  = 0;
        longint r    = 0;
        int     k    = apx ? K : 0;
        int     sh   = int'(bb) % WIDTH;
        case (s)
            3'd0: r = loa_ref(x, z, k);
            3'd1: begin
                for (int i = 0; i < MW; i++)
                    if (((z >> i) & 1) != 0)
                        acc = loa_ref(acc, (x % (longint'(1) << MW)) << i, k) % (longint'(1) << (2 * MW));
                r = acc;
            end
            3'd2: r = x & z;
            3'd3: r = x | z;
            3'd4: r = x ^ z;
            3'd5: r = ~x & mask;
            3'd6: r = (x << sh) & mask;
            default: r = x >> sh;
        endcase
        return (WIDTH+1)'(r);
    endfunction

    task automatic check(input string name, input logic [WIDTH:0] got, input logic [WIDTH:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    // Monitor: every transfer (out_valid && out_ready) pops one expected result.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output: got y=%h, required no output", y);
            end else begin
                logic [WIDTH:0] e;
                e = sb.pop_front();
                if (y !== e) begin
                    n_err++;
                    $display("FAIL result: got y=%h, required %h", y, e);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the acceptance edge.
    task automatic issue(input logic [2:0] s, input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                         input logic apx, input bit lit, input logic [WIDTH:0] lit_y, output int waited);
        waited = 0;
        sel = s; a = aa; b = bb; approx_en = apx; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: in_ready=0, required 1");
        end else begin
            sb.push_back(lit ? lit_y : model(s, aa, bb, apx));
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        a         = WIDTH'($urandom);
        b         = WIDTH'($urandom);
        sel       = 3'($urandom_range(0, 7));
        approx_en = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_valid(output int n, output int busy_bad);
        n = 0;
        busy_bad = 0;
        do begin
            @(negedge clk);
            n++;
            if (!out_valid && in_ready) busy_bad++;
        end while (!out_valid && n < 50);
    endtask

    task automatic directed(input string name, input logic [2:0] s, input logic [WIDTH-1:0] aa,
                            input logic [WIDTH-1:0] bb, input logic apx, input logic [WIDTH:0] exp_y,
                            input int lat);
        int w, n, bad;
        issue(s, aa, bb, apx, 1'b1, exp_y, w);
        wait_valid(n, bad);
        check({name, "_latency"}, (WIDTH+1)'(n), (WIDTH+1)'(lat));
        if (s == 3'd1) check({name, "_busy_in_ready"}, (WIDTH+1)'(bad), '0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w, n, bad;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_y", y, '0);
        check("reset_out_valid", (WIDTH+1)'(out_valid), '0);
        check("reset_in_ready", (WIDTH+1)'(in_ready), 'd1);
        @(posedge clk);
        #1;

        ready_mode = 1;
        directed("add_apx",  3'd0, 16'h000F, 16'h0001, 1'b1, 17'h0000F, 1);
        directed("add_ex",   3'd0, 16'h000F, 16'h0001, 1'b0, 17'h00010, 1);
        directed("add_cout", 3'd0, 16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1);
        directed("mul_apx",  3'd1, 16'h0003, 16'h0003, 1'b1, 17'h00007, MW + 1);
        directed("mul_ex",   3'd1, 16'h0003, 16'h0003, 1'b0, 17'h00009, MW + 1);
        directed("mul_zero", 3'd1, 16'h0000, 16'h00AB, 1'b1, 17'h00000, MW + 1);
        directed("shl",      3'd6, 16'h0001, 16'h000F, 1'b0, 17'h08000, 1);
        directed("shr",      3'd7, 16'h8000, 16'h0013, 1'b0, 17'h01000, 1);
        directed("not",      3'd5, 16'h1234, 16'hFFFF, 1'b0, 17'h0EDCB, 1);

        // Backpressure, then drain and accept in the same cycle.
        ready_mode = 0;
        issue(3'd4, 16'h00FF, 16'h0F0F, 1'b0, 1'b1, 17'h00FF0, w);
        wait_valid(n, bad);
        check("bp_latency", (WIDTH+1)'(n), 'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_y", y, 17'h00FF0);
            check("bp_valid_ready", (WIDTH+1)'({out_valid, in_ready}), 'd2);
        end
        @(posedge clk);
        #1;
        ready_mode = 1;
        issue(3'd0, 16'h1111, 16'h2222, 1'b0, 1'b1, 17'h03333, w);
        check("bp_same_cycle_accept", (WIDTH+1)'(w), '0);
        @(negedge clk);
        check("bp_next_valid", (WIDTH+1)'(out_valid), 'd1);
        @(posedge clk);
        #1;

        // Reset four cycles into a multiply discards it.
        issue(3'd1, 16'h0003, 16'h0003, 1'b1, 1'b1, 17'h00007, w);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("rst_in_ready", (WIDTH+1)'(in_ready), 'd1);
        check("rst_y", y, '0);
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) bad++;
            @(negedge clk);
        end
        check("rst_no_output", (WIDTH+1)'(bad), '0);
        @(posedge clk);
        #1;

        // Back-to-back non-mul ops with out_ready held high.
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] s;
            s = 3'($urandom_range(0, 7));
            if (s == 3'd1) s = 3'd2;
            sel = s; a = WIDTH'($urandom); b = WIDTH'($urandom);
            approx_en = 1'($urandom_range(0, 1)); in_valid = 1'b1;
            @(negedge clk);
            if (!in_ready) bad++;
            if (i > 0 && !out_valid) bad++;
            if (in_ready) sb.push_back(model(s, a, b, approx_en));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("throughput", (WIDTH+1)'(bad), '0);

        // Randomized ops with random backpressure.
        ready_mode = 2;
        for (int i = 0; i < 300; i++) begin
            issue(3'($urandom_range(0, 7)), WIDTH'($urandom), WIDTH'($urandom),
                  1'($urandom_range(0, 1)), 1'b0, '0, w);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        ready_mode = 1;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("sb_drain", (WIDTH+1)'(sb.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
